cu_sequencer: RTL and testbench
===============================

Name: cu_sequencer

Overview:
- Parametrised instruction-cycle sequencer for the control unit.
- Replaces the fixed free-running 4-phase result counter with a handshaked FSM: fetch, decode, execute, commit.
- Owns PC, IR, next-PC selection (sequential/branch/JAL/JALR), 1-bit branch history, retired-instruction count, and sticky halt with cause code.
- Sits between memfetch, the instruction decoder and the ALU; the register file stays outside.

Parameters:
- XLEN, 32, datapath/PC width.
- IMEM_DEPTH, 128, instruction words; PC >= IMEM_DEPTH*4 is out of range.
- PC_STEP, 4, sequential PC increment.
- RESET_PC, 0, PC value after reset.
- TIMEOUT_CYCLES, 64, maximum wait in any handshake state; 0 disables the watchdog.
- CNT_W, 32, retired counter width.

Ports:
- soc_clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- run_en  in  1  level; permits starting a new instruction.
- fetch_req  out  1  held high in FETCH.
- fetch_addr  out  XLEN  equals pc.
- fetch_ready  in  1  instruction valid.
- fetch_instr  in  32  instruction word.
- ir  out  32  latched instruction.
- decode_start  out  1  one-cycle pulse.
- idu_ready  in  1  decode valid.
- idu_stall  in  1  hazard; holds DECODE.
- ctrl_class  in  3  0 normal, 1 branch, 2 jal, 3 jalr, 4 ecall, 5 ebreak, 6-7 invalid.
- invalid_instruction  in  1  decoder error.
- pc_offset  in  XLEN  immediate offset for branch/jal.
- alu_start  out  1  one-cycle pulse.
- alu_done  in  1  result valid.
- alu_result  in  XLEN  jalr target source.
- alu_branch_taken  in  1  branch condition.
- alu_err  in  1  ALU error.
- wb_en  out  1  one-cycle commit pulse.
- wb_link  out  XLEN  pc+PC_STEP (return address).
- pc  out  XLEN  current PC.
- pred_taken  out  1  last branch outcome.
- retired_count  out  CNT_W  saturating count of committed instructions.
- halted  out  1  sticky.
- halt_cause  out  3  0 none, 1 ecall, 2 ebreak, 3 invalid, 4 alu_err, 5 pc range, 6 timeout, 7 misaligned target.
- state  out  3  FSM state for debug.

Behaviour:
- Reset (async): state=IDLE, pc=RESET_PC, ir=0, pred_taken=0, retired_count=0, halted=0, halt_cause=0. All pulses/requests are 0; wb_link=0.
- IDLE: run_en=1 -> FETCH next cycle.
- FETCH:
  - fetch_req=1 and fetch_addr=pc, both stable until fetch_ready.
  - fetch_ready=1: ir<=fetch_instr, -> DECODE.
- DECODE:
  - decode_start=1 in the first cycle only.
  - Advance when idu_ready=1 and idu_stall=0; idu_stall=1 holds the state regardless of idu_ready.
  - On advance, halt priority: invalid_instruction or ctrl_class>=6 (cause 3) > ecall (1) > ebreak (2).
  - Otherwise -> EXEC.
- EXEC:
  - alu_start=1 in the first cycle only.
  - alu_done=1: alu_err -> HALT cause 4; else latch alu_result/alu_branch_taken, -> COMMIT.
- COMMIT (exactly 1 cycle):
  - wb_en=1, wb_link=pc+PC_STEP.
  - next_pc:
    - normal: pc+PC_STEP.
    - branch: taken ? pc+pc_offset : pc+PC_STEP.
    - jal: pc+pc_offset.
    - jalr: alu_result with bit0 cleared.
  - All adds are modulo 2^XLEN.
  - retired_count += 1, saturating at all-ones.
  - On branch: pred_taken <= taken.
  - next_pc[1:0]!=0 -> HALT cause 7, pc unchanged.
  - Else if next_pc >= IMEM_DEPTH*4 -> HALT cause 5, pc unchanged.
  - Else pc<=next_pc, then -> FETCH if run_en, else IDLE.
- Halting instructions: ecall, ebreak and invalid instructions do not commit (no wb_en, count unchanged).
- Watchdog:
  - A counter resets on every state entry and counts wait cycles in FETCH/DECODE/EXEC.
  - Reaching TIMEOUT_CYCLES -> HALT cause 6.
- HALT: absorbing; only reset leaves it. halted=1 from the cycle HALT is entered; halt_cause holds the first cause.
- run_en deasserted mid-instruction: the current instruction completes, then -> IDLE.
- Latency: minimum 4 cycles per instruction with same-cycle responders (FETCH, DECODE, EXEC, COMMIT).
- Reset asserted mid-operation aborts immediately; there is no partial commit.

Decomposition:
- Package cu_pkg:
  - ctrl_class_e enum
  - halt_cause_e enum
  - cu_state_e {IDLE, FETCH, DECODE, EXEC, COMMIT, HALT}
  - PC_STEP_DEFAULT constant
- One sub-module: cu_next_pc, combinational next-PC, misalignment and range check. The FSM, watchdog and counters remain in cu_sequencer.

Test Plan:
- Zero-wait responders, 3 normal instructions, run_en=1 -> wb_en every 4th cycle, pc 0->4->8->12, retired_count=3.
- Branch at pc=8, pc_offset=-8, taken=1 -> pc=0, pred_taken=1; repeat with taken=0 -> pc=12, pred_taken=0.
- jalr at pc=16, alu_result=0x21 -> pc=0x20, wb_link=0x14; alu_result=0x22 -> halted, cause 7, pc stays 16.
- idu_stall high 5 cycles with idu_ready=1 -> DECODE held, decode_start only 1 pulse; TIMEOUT_CYCLES=4 with fetch_ready low 4 cycles -> cause 6.
- ctrl_class=4 at pc=4 -> halted cause 1, no wb_en, count unchanged; a later alu_err does not change the cause.
- pc=IMEM_DEPTH*4-4 normal commit -> cause 5; reset asserted mid-EXEC -> pc=RESET_PC, all outputs at reset values in the same cycle.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and constants for the control-unit instruction sequencer.
package cu_pkg;

  typedef enum logic [2:0] {
    CC_NORMAL = 3'd0,
    CC_BRANCH = 3'd1,
    CC_JAL    = 3'd2,
    CC_JALR   = 3'd3,
    CC_ECALL  = 3'd4,
    CC_EBREAK = 3'd5,
    CC_INV6   = 3'd6,
    CC_INV7   = 3'd7
  } ctrl_class_e;

  typedef enum logic [2:0] {
    HC_NONE     = 3'd0,
    HC_ECALL    = 3'd1,
    HC_EBREAK   = 3'd2,
    HC_INVALID  = 3'd3,
    HC_ALU_ERR  = 3'd4,
    HC_PC_RANGE = 3'd5,
    HC_TIMEOUT  = 3'd6,
    HC_MISALIGN = 3'd7
  } halt_cause_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_COMMIT = 3'd4,
    S_HALT   = 3'd5
  } cu_state_e;

  localparam int PC_STEP_DEFAULT = 4;

endpackage

// File: rtl/cu_next_pc.sv
// Combinational next-PC selection with alignment and IMEM range checks.
module cu_next_pc
  import cu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int IMEM_DEPTH = 128,
  parameter int PC_STEP    = PC_STEP_DEFAULT
) (
  input  logic [XLEN-1:0] pc,
  input  ctrl_class_e     cls,
  input  logic            taken,
  input  logic [XLEN-1:0] offset,
  input  logic [XLEN-1:0] alu_result,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] link,
  output logic            misaligned,
  output logic            out_of_range
);

  localparam logic [XLEN-1:0] STEP  = XLEN'(PC_STEP);
  localparam logic [XLEN-1:0] LIMIT = XLEN'(IMEM_DEPTH * 4);

  always_comb begin
    link    = pc + STEP;
    next_pc = link;
    case (cls)
      CC_BRANCH: next_pc = taken ? pc + offset : link;
      CC_JAL:    next_pc = pc + offset;
      CC_JALR:   next_pc = {alu_result[XLEN-1:1], 1'b0};
      default:   next_pc = link;
    endcase
    misaligned   = |next_pc[1:0];
    out_of_range = next_pc >= LIMIT;
  end

endmodule

// File: rtl/cu_sequencer.sv
// Handshaked fetch/decode/execute/commit sequencer owning PC, IR, branch
// history, retired count, watchdog and sticky halt cause.
module cu_sequencer
  import cu_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int IMEM_DEPTH     = 128,
  parameter int PC_STEP        = PC_STEP_DEFAULT,
  parameter int RESET_PC       = 0,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 32
) (
  input  logic             soc_clk,
  input  logic             reset,
  input  logic             run_en,
  output logic             fetch_req,
  output logic [XLEN-1:0]  fetch_addr,
  input  logic             fetch_ready,
  input  logic [31:0]      fetch_instr,
  output logic [31:0]      ir,
  output logic             decode_start,
  input  logic             idu_ready,
  input  logic             idu_stall,
  input  logic [2:0]       ctrl_class,
  input  logic             invalid_instruction,
  input  logic [XLEN-1:0]  pc_offset,
  output logic             alu_start,
  input  logic             alu_done,
  input  logic [XLEN-1:0]  alu_result,
  input  logic             alu_branch_taken,
  input  logic             alu_err,
  output logic             wb_en,
  output logic [XLEN-1:0]  wb_link,
  output logic [XLEN-1:0]  pc,
  output logic             pred_taken,
  output logic [CNT_W-1:0] retired_count,
  output logic             halted,
  output logic [2:0]       halt_cause,
  output logic [2:0]       state
);

  localparam logic [XLEN-1:0] RST_PC   = XLEN'(RESET_PC);
  localparam logic [31:0]     WD_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  localparam logic            WD_ON    = (TIMEOUT_CYCLES != 0);

  cu_state_e        state_q, state_d;
  halt_cause_e      cause_q, cause_d;
  ctrl_class_e      cls_q, cls_d;
  logic [XLEN-1:0]  pc_q, pc_d, off_q, off_d, res_q, res_d;
  logic [31:0]      ir_q, ir_d, wd_q, wd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tkn_q, tkn_d, pred_q, pred_d, first_q, first_d;
  logic [XLEN-1:0]  next_pc, link;
  logic             misaligned, out_of_range, wd_hit, waiting;

  cu_next_pc #(.XLEN(XLEN), .IMEM_DEPTH(IMEM_DEPTH), .PC_STEP(PC_STEP)) u_next_pc (
    .pc(pc_q), .cls(cls_q), .taken(tkn_q), .offset(off_q), .alu_result(res_q),
    .next_pc(next_pc), .link(link), .misaligned(misaligned), .out_of_range(out_of_range)
  );

  always_comb begin
    state_d = state_q; cause_d = cause_q; cls_d = cls_q;
    pc_d = pc_q; off_d = off_q; res_d = res_q; ir_d = ir_q;
    cnt_d = cnt_q; tkn_d = tkn_q; pred_d = pred_q;
    fetch_req = 1'b0; decode_start = 1'b0; alu_start = 1'b0;
    wb_en = 1'b0; wb_link = '0;
    wd_hit = WD_ON && (wd_q == WD_LIMIT);
    waiting = 1'b0;
    case (state_q)
      S_IDLE: if (run_en) state_d = S_FETCH;
      S_FETCH: begin
        fetch_req = 1'b1;
        waiting   = 1'b1;
        if (fetch_ready) begin
          ir_d = fetch_instr; state_d = S_DECODE;
        end else if (wd_hit) begin
          state_d = S_HALT; cause_d = HC_TIMEOUT;
        end
      end
      S_DECODE: begin
        decode_start = first_q;
        waiting      = 1'b1;
        if (idu_ready && !idu_stall) begin
          // Latch decoder outputs so COMMIT does not depend on them staying put.
          cls_d = ctrl_class_e'(ctrl_class);
          off_d = pc_offset;
          if (invalid_instruction || ctrl_class >= 3'd6) begin
            state_d = S_HALT; cause_d = HC_INVALID;
          end else if (ctrl_class == CC_ECALL) begin
            state_d = S_HALT; cause_d = HC_ECALL;
          end else if (ctrl_class == CC_EBREAK) begin
            state_d = S_HALT; cause_d = HC_EBREAK;
          end else begin
            state_d = S_EXEC;
          end
        end else if (wd_hit) begin
          state_d = S_HALT; cause_d = HC_TIMEOUT;
        end
      end
      S_EXEC: begin
        alu_start = first_q;
        waiting   = 1'b1;
        if (alu_done) begin
          if (alu_err) begin
            state_d = S_HALT; cause_d = HC_ALU_ERR;
          end else begin
            res_d = alu_result; tkn_d = alu_branch_taken; state_d = S_COMMIT;
          end
        end else if (wd_hit) begin
          state_d = S_HALT; cause_d = HC_TIMEOUT;
        end
      end
      S_COMMIT: begin
        wb_en   = 1'b1;
        wb_link = link;
        cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        if (cls_q == CC_BRANCH) pred_d = tkn_q;
        if (misaligned) begin
          state_d = S_HALT; cause_d = HC_MISALIGN;
        end else if (out_of_range) begin
          state_d = S_HALT; cause_d = HC_PC_RANGE;
        end else begin
          pc_d    = next_pc;
          state_d = run_en ? S_FETCH : S_IDLE;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
    first_d = (state_d != state_q);
    if (first_d)                wd_d = '0;
    else if (waiting && WD_ON)  wd_d = wd_q + 32'd1;
    else                        wd_d = wd_q;
  end

  always_ff @(posedge soc_clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;  cause_q <= HC_NONE;  cls_q <= CC_NORMAL;
      pc_q    <= RST_PC;  off_q   <= '0;       res_q <= '0;
      ir_q    <= '0;      wd_q    <= '0;       cnt_q <= '0;
      tkn_q   <= 1'b0;    pred_q  <= 1'b0;     first_q <= 1'b1;
    end else begin
      state_q <= state_d; cause_q <= cause_d;  cls_q <= cls_d;
      pc_q    <= pc_d;    off_q   <= off_d;    res_q <= res_d;
      ir_q    <= ir_d;    wd_q    <= wd_d;     cnt_q <= cnt_d;
      tkn_q   <= tkn_d;   pred_q  <= pred_d;   first_q <= first_d;
    end
  end

  assign fetch_addr    = pc_q;
  assign pc            = pc_q;
  assign ir            = ir_q;
  assign pred_taken    = pred_q;
  assign retired_count = cnt_q;
  assign halted        = (state_q == S_HALT);
  assign halt_cause    = cause_q;
  assign state         = state_q;

endmodule

// File: tb/tb_cu_sequencer.sv
// Directed-vector bench for cu_sequencer; a second instance with a short
// watchdog covers the timeout path.
module tb_cu_sequencer;
  import cu_pkg::*;

  logic        soc_clk = 1'b0;
  logic        reset = 1'b1, run_en = 1'b0, fetch_ready = 1'b1, idu_ready = 1'b1;
  logic        idu_stall = 1'b0, invalid_instruction = 1'b0, alu_done = 1'b1;
  logic        alu_branch_taken = 1'b0, alu_err = 1'b0;
  logic [31:0] fetch_instr = '0, pc_offset = '0, alu_result = '0;
  logic [2:0]  ctrl_class = '0;

  logic        fetch_req, decode_start, alu_start, wb_en, pred_taken, halted;
  logic [31:0] fetch_addr, ir, wb_link, pc, retired_count;
  logic [2:0]  halt_cause, state;

  logic        w_fetch_req, w_decode_start, w_alu_start, w_wb_en, w_pred_taken, w_halted;
  logic [31:0] w_fetch_addr, w_ir, w_wb_link, w_pc, w_retired_count;
  logic [2:0]  w_halt_cause, w_state;

  int passed = 0, total = 0;

  always #5 soc_clk = ~soc_clk;

  cu_sequencer dut (
    .soc_clk(soc_clk), .reset(reset), .run_en(run_en),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .ir(ir), .decode_start(decode_start),
    .idu_ready(idu_ready), .idu_stall(idu_stall), .ctrl_class(ctrl_class),
    .invalid_instruction(invalid_instruction), .pc_offset(pc_offset),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .alu_branch_taken(alu_branch_taken), .alu_err(alu_err),
    .wb_en(wb_en), .wb_link(wb_link), .pc(pc), .pred_taken(pred_taken),
    .retired_count(retired_count), .halted(halted), .halt_cause(halt_cause),
    .state(state)
  );

  cu_sequencer #(.TIMEOUT_CYCLES(4)) dut_wd (
    .soc_clk(soc_clk), .reset(reset), .run_en(run_en),
    .fetch_req(w_fetch_req), .fetch_addr(w_fetch_addr), .fetch_ready(fetch_ready),
    .fetch_instr(fetch_instr), .ir(w_ir), .decode_start(w_decode_start),
    .idu_ready(idu_ready), .idu_stall(idu_stall), .ctrl_class(ctrl_class),
    .invalid_instruction(invalid_instruction), .pc_offset(pc_offset),
    .alu_start(w_alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .alu_branch_taken(alu_branch_taken), .alu_err(alu_err),
    .wb_en(w_wb_en), .wb_link(w_wb_link), .pc(w_pc), .pred_taken(w_pred_taken),
    .retired_count(w_retired_count), .halted(w_halted), .halt_cause(w_halt_cause),
    .state(w_state)
  );

  task automatic tick();
    @(posedge soc_clk); #1;
  endtask

  task automatic do_reset();
    run_en = 0; fetch_ready = 1; fetch_instr = '0; idu_ready = 1; idu_stall = 0;
    ctrl_class = 0; invalid_instruction = 0; pc_offset = '0; alu_done = 1;
    alu_result = '0; alu_branch_taken = 0; alu_err = 0;
    reset = 1; @(posedge soc_clk); @(negedge soc_clk); reset = 0;
  endtask

  // Runs one instruction from IDLE with zero-wait responders; samples the COMMIT slot.
  task automatic go(input logic [2:0] cls, input logic [31:0] off, input logic [31:0] res,
                    input logic tkn, output logic wbe, output logic [31:0] lnk);
    ctrl_class = cls; pc_offset = off; alu_result = res; alu_branch_taken = tkn;
    run_en = 1; tick(); run_en = 0; tick(); tick(); tick();
    wbe = wb_en; lnk = wb_link;
    tick();
  endtask

  task automatic test_reset();
    reset = 1; #2;
    total++; if (state !== 3'd0) $display("FAIL rst_state got %0d exp 0", state); else passed++;
    total++; if (pc !== 32'd0) $display("FAIL rst_pc got %0h exp 0", pc); else passed++;
    total++; if ({fetch_req, decode_start, alu_start, wb_en, halted, pred_taken} !== 6'b0)
      $display("FAIL rst_flags got %b exp 000000", {fetch_req, decode_start, alu_start, wb_en, halted, pred_taken});
    else passed++;
    total++; if ({ir, wb_link, retired_count} !== 96'd0) $display("FAIL rst_regs got %0h exp 0", {ir, wb_link, retired_count}); else passed++;
    total++; if (halt_cause !== 3'd0) $display("FAIL rst_cause got %0d exp 0", halt_cause); else passed++;
  endtask

  task automatic test_sequential();
    do_reset();
    fetch_instr = 32'h00100093;
    run_en = 1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      total++; if (wb_en !== (i % 4 == 0)) $display("FAIL seq_wb_en cyc %0d got %b exp %b", i, wb_en, (i % 4 == 0)); else passed++;
      if (i % 4 == 0) begin
        total++; if (pc !== 32'(4 * (i / 4 - 1))) $display("FAIL seq_pc cyc %0d got %0h exp %0h", i, pc, 4 * (i / 4 - 1)); else passed++;
        total++; if (wb_link !== 32'(4 * (i / 4))) $display("FAIL seq_link cyc %0d got %0h exp %0h", i, wb_link, 4 * (i / 4)); else passed++;
      end
      if (i == 2) begin
        total++; if (ir !== 32'h00100093) $display("FAIL seq_ir got %0h exp 00100093", ir); else passed++;
      end
    end
    run_en = 0; tick();
    total++; if (state !== 3'd0) $display("FAIL seq_idle got %0d exp 0", state); else passed++;
    total++; if (pc !== 32'd12) $display("FAIL seq_pc_end got %0h exp c", pc); else passed++;
    total++; if (retired_count !== 32'd3) $display("FAIL seq_count got %0d exp 3", retired_count); else passed++;
  endtask

  task automatic test_branch();
    logic wbe; logic [31:0] lk;
    do_reset();
    go(3'd0, 0, 0, 0, wbe, lk); go(3'd0, 0, 0, 0, wbe, lk);
    go(3'd1, 32'hFFFF_FFF8, 0, 1, wbe, lk);
    total++; if (pc !== 32'd0) $display("FAIL br_taken_pc got %0h exp 0", pc); else passed++;
    total++; if (pred_taken !== 1'b1) $display("FAIL br_taken_pred got %b exp 1", pred_taken); else passed++;
    go(3'd0, 0, 0, 0, wbe, lk); go(3'd0, 0, 0, 0, wbe, lk);
    go(3'd1, 32'hFFFF_FFF8, 0, 0, wbe, lk);
    total++; if (pc !== 32'd12) $display("FAIL br_nt_pc got %0h exp c", pc); else passed++;
    total++; if (pred_taken !== 1'b0) $display("FAIL br_nt_pred got %b exp 0", pred_taken); else passed++;
    total++; if (retired_count !== 32'd6) $display("FAIL br_count got %0d exp 6", retired_count); else passed++;
  endtask

  task automatic test_jalr();
    logic wbe; logic [31:0] lk;
    do_reset();
    for (int i = 0; i < 4; i++) go(3'd0, 0, 0, 0, wbe, lk);
    go(3'd3, 0, 32'h21, 0, wbe, lk);
    total++; if (lk !== 32'h14) $display("FAIL jalr_link got %0h exp 14", lk); else passed++;
    total++; if (pc !== 32'h20) $display("FAIL jalr_pc got %0h exp 20", pc); else passed++;
    go(3'd2, 32'hFFFF_FFF0, 0, 0, wbe, lk);
    total++; if (pc !== 32'h10) $display("FAIL jal_pc got %0h exp 10", pc); else passed++;
    go(3'd3, 0, 32'h22, 0, wbe, lk);
    total++; if (halted !== 1'b1) $display("FAIL mis_halted got %b exp 1", halted); else passed++;
    total++; if (halt_cause !== 3'd7) $display("FAIL mis_cause got %0d exp 7", halt_cause); else passed++;
    total++; if (pc !== 32'h10) $display("FAIL mis_pc got %0h exp 10", pc); else passed++;
  endtask

  task automatic test_stall();
    do_reset();
    idu_stall = 1; run_en = 1; tick(); run_en = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (state !== 3'd2) $display("FAIL stall_state cyc %0d got %0d exp 2", i, state); else passed++;
      total++; if (decode_start !== (i == 0)) $display("FAIL stall_dstart cyc %0d got %b exp %b", i, decode_start, (i == 0)); else passed++;
    end
    idu_stall = 0; tick();
    total++; if (state !== 3'd3 || alu_start !== 1'b1) $display("FAIL stall_exec got st %0d as %b exp 3/1", state, alu_start); else passed++;
    tick(); tick();
    total++; if (retired_count !== 32'd1) $display("FAIL stall_count got %0d exp 1", retired_count); else passed++;
  endtask

  task automatic test_timeout();
    do_reset();
    fetch_ready = 0; run_en = 1; tick(); run_en = 0;
    total++; if (w_fetch_req !== 1'b1 || w_fetch_addr !== 32'd0) $display("FAIL wd_req got %b/%0h exp 1/0", w_fetch_req, w_fetch_addr); else passed++;
    tick(); tick(); tick();
    total++; if (w_state !== 3'd1 || w_halted !== 1'b0) $display("FAIL wd_early got st %0d h %b exp 1/0", w_state, w_halted); else passed++;
    tick();
    total++; if (w_halted !== 1'b1) $display("FAIL wd_halted got %b exp 1", w_halted); else passed++;
    total++; if (w_halt_cause !== 3'd6) $display("FAIL wd_cause got %0d exp 6", w_halt_cause); else passed++;
    total++; if (state !== 3'd1) $display("FAIL wd_long_state got %0d exp 1", state); else passed++;
    fetch_ready = 1;
  endtask

  task automatic test_ecall();
    logic wbe; logic [31:0] lk;
    do_reset();
    go(3'd0, 0, 0, 0, wbe, lk);
    go(3'd4, 0, 0, 0, wbe, lk);
    total++; if (wbe !== 1'b0) $display("FAIL ecall_wb got %b exp 0", wbe); else passed++;
    total++; if (halted !== 1'b1 || halt_cause !== 3'd1) $display("FAIL ecall_cause got %b/%0d exp 1/1", halted, halt_cause); else passed++;
    total++; if (retired_count !== 32'd1 || pc !== 32'd4) $display("FAIL ecall_state got cnt %0d pc %0h exp 1/4", retired_count, pc); else passed++;
    alu_err = 1;
    go(3'd0, 0, 0, 0, wbe, lk);
    total++; if (halt_cause !== 3'd1 || state !== 3'd5) $display("FAIL ecall_sticky got %0d/%0d exp 1/5", halt_cause, state); else passed++;
  endtask

  task automatic test_errors();
    logic wbe; logic [31:0] lk;
    do_reset(); invalid_instruction = 1;
    go(3'd4, 0, 0, 0, wbe, lk);
    total++; if (halt_cause !== 3'd3) $display("FAIL inv_prio got %0d exp 3", halt_cause); else passed++;
    do_reset();
    go(3'd6, 0, 0, 0, wbe, lk);
    total++; if (halt_cause !== 3'd3) $display("FAIL inv_class got %0d exp 3", halt_cause); else passed++;
    do_reset();
    go(3'd5, 0, 0, 0, wbe, lk);
    total++; if (halt_cause !== 3'd2) $display("FAIL ebreak got %0d exp 2", halt_cause); else passed++;
    do_reset(); alu_err = 1;
    go(3'd0, 0, 0, 0, wbe, lk);
    total++; if (halt_cause !== 3'd4 || wbe !== 1'b0) $display("FAIL alu_err got %0d/%b exp 4/0", halt_cause, wbe); else passed++;
  endtask

  task automatic test_range();
    logic wbe; logic [31:0] lk;
    do_reset();
    go(3'd2, 32'd508, 0, 0, wbe, lk);
    total++; if (pc !== 32'd508 || halted !== 1'b0) $display("FAIL rng_jal got %0h/%b exp 1fc/0", pc, halted); else passed++;
    go(3'd0, 0, 0, 0, wbe, lk);
    total++; if (halt_cause !== 3'd5 || halted !== 1'b1) $display("FAIL rng_cause got %0d/%b exp 5/1", halt_cause, halted); else passed++;
    total++; if (pc !== 32'd508) $display("FAIL rng_pc got %0h exp 1fc", pc); else passed++;
  endtask

  task automatic test_reset_mid_exec();
    logic wbe; logic [31:0] lk;
    do_reset();
    go(3'd0, 0, 0, 0, wbe, lk); go(3'd0, 0, 0, 0, wbe, lk);
    alu_done = 0; run_en = 1; tick(); run_en = 0; tick(); tick();
    total++; if (state !== 3'd3 || alu_start !== 1'b1) $display("FAIL mid_exec got st %0d as %b exp 3/1", state, alu_start); else passed++;
    #2 reset = 1; #1;
    total++; if (state !== 3'd0 || pc !== 32'd0) $display("FAIL mid_rst got st %0d pc %0h exp 0/0", state, pc); else passed++;
    total++; if ({alu_start, wb_en, fetch_req, halted} !== 4'b0 || retired_count !== 32'd0 || ir !== 32'd0)
      $display("FAIL mid_rst_outs got %b cnt %0d ir %0h exp 0", {alu_start, wb_en, fetch_req, halted}, retired_count, ir);
    else passed++;
    alu_done = 1;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_jalr();
    test_stall();
    test_timeout();
    test_ecall();
    test_errors();
    test_range();
    test_reset_mid_exec();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
